// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B decoder driving a saturating position counter
module quad_decoder #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  input  logic             B,
  input  logic             Load,
  input  logic [WIDTH-1:0] IN,
  input  logic             Clear,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             Up,
  output logic             Down,
  output logic             Err
);

  typedef enum logic {
    ST_PRIME,
    ST_TRACK
  } state_t;

  localparam int PW = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_prev;
  logic [PW-1:0]          r_prime_cnt;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [WIDTH-1:0]       r_counter;
  logic                   r_up;
  logic                   r_down;
  logic                   r_err;

  logic [1:0] w_s;
  logic [1:0] w_idx_s;
  logic [1:0] w_idx_prev;
  logic [1:0] w_delta;
  logic       w_prime_done;
  logic       w_decode_en;
  logic       w_step_up;
  logic       w_step_down;
  logic       w_illegal;

  // Synchronized phase; Gray code 00,01,11,10 maps to positions 0..3 so a
  // modulo-4 position difference gives direction (1 fwd, 3 rev, 2 illegal).
  assign w_s          = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  assign w_idx_s      = {w_s[1], w_s[1] ^ w_s[0]};
  assign w_idx_prev   = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_delta      = w_idx_s - w_idx_prev;
  assign w_prime_done = (r_prime_cnt == PRIME_LAST);

  // Synchronizer chains for A and B; prev tracks the last decoded phase every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_prev   <= 2'b00;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], A};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], B};
      r_prev   <= w_s;
    end
  end

  // State register plus prime counter that holds off decoding after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_PRIME;
      r_prime_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_PRIME) begin
        r_prime_cnt <= r_prime_cnt + 1'b1;
      end
    end
  end

  // Next-state and step decode; steps are only recognised once tracking.
  always_comb begin
    w_state_next = r_state;
    w_decode_en  = 1'b0;
    w_step_up    = 1'b0;
    w_step_down  = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      ST_PRIME: begin
        if (w_prime_done) begin
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        w_decode_en = 1'b1;
      end
      default: begin
        w_state_next = ST_PRIME;
      end
    endcase
    if (w_decode_en) begin
      w_step_up   = (w_delta == 2'd1);
      w_step_down = (w_delta == 2'd3);
      w_illegal   = (w_delta == 2'd2);
    end
  end

  // Position counter: load beats stepping; steps saturate at either end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_counter <= '0;
    end else if (Load) begin
      r_counter <= IN;
    end else if (w_step_up && (r_counter != '1)) begin
      r_counter <= r_counter + 1'b1;
    end else if (w_step_down && (r_counter != '0)) begin
      r_counter <= r_counter - 1'b1;
    end
  end

  // Step pulses and sticky error flag; a new illegal transition beats Clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_up   <= w_step_up;
      r_down <= w_step_down;
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (Clear) begin
        r_err <= 1'b0;
      end
    end
  end

  assign Counter = r_counter;
  assign High    = &r_counter;
  assign Low     = ~|r_counter;
  assign Up      = r_up;
  assign Down    = r_down;
  assign Err     = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - self-checking bench for quad_decoder against a sampled-history model
module tb_quad_decoder;

  localparam int WIDTH = 5;
  localparam int SS    = 2;

  logic             CLK;
  logic             RST;
  logic             A;
  logic             B;
  logic             Load;
  logic [WIDTH-1:0] IN;
  logic             Clear;
  logic [WIDTH-1:0] Counter;
  logic             High;
  logic             Low;
  logic             Up;
  logic             Down;
  logic             Err;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Load(Load), .IN(IN), .Clear(Clear),
    .Counter(Counter), .High(High), .Low(Low), .Up(Up), .Down(Down), .Err(Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: AB levels sampled at each edge since reset release
  logic [1:0]       ab_hist [0:8191];
  int               m_edge;
  logic [WIDTH-1:0] m_cnt;
  logic             m_up;
  logic             m_down;
  logic             m_err;
  logic [1:0]       ab_cur;

  function automatic logic [1:0] fwd_next(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] g);
    return fwd_next(fwd_next(fwd_next(g)));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_cnt  = '0;
    m_up   = 1'b0;
    m_down = 1'b0;
    m_err  = 1'b0;
  endtask

  // An AB level sampled at edge k is decided against the one at edge k-1
  // at edge k+SS, once the post-reset settling window is over.
  task automatic model_edge();
    logic [1:0] cur, old;
    logic st_up, st_dn, ill;
    st_up = 1'b0; st_dn = 1'b0; ill = 1'b0;
    if (RST) begin
      m_edge++;
      ab_hist[m_edge] = {A, B};
      if (m_edge >= SS + 2) begin
        cur = ab_hist[m_edge - SS];
        old = ab_hist[m_edge - SS - 1];
        if (cur == fwd_next(old))      st_up = 1'b1;
        else if (old == fwd_next(cur)) st_dn = 1'b1;
        else if (cur != old)           ill   = 1'b1;
      end
      m_up   = st_up;
      m_down = st_dn;
      if (Load)                                   m_cnt = IN;
      else if (st_up && m_cnt != (2**WIDTH) - 1)  m_cnt = m_cnt + 1;
      else if (st_dn && m_cnt != 0)               m_cnt = m_cnt - 1;
      if (ill)        m_err = 1'b1;
      else if (Clear) m_err = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("counter", 8'(Counter), 8'(m_cnt));
    chk("high",    8'(High),    8'(m_cnt == (2**WIDTH) - 1));
    chk("low",     8'(Low),     8'(m_cnt == 0));
    chk("up",      8'(Up),      8'(m_up));
    chk("down",    8'(Down),    8'(m_down));
    chk("err",     8'(Err),     8'(m_err));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    ab_cur = ab;
    A = ab[1];
    B = ab[0];
    repeat (n) tick();
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    Load = 1'b1;
    IN   = v;
    tick();
    Load = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_counter", 8'(Counter), 8'h00);
    chk("rst_high",    8'(High),    8'h00);
    chk("rst_low",     8'(Low),     8'h01);
    chk("rst_up",      8'(Up),      8'h00);
    chk("rst_down",    8'(Down),    8'h00);
    chk("rst_err",     8'(Err),     8'h00);
  endtask

  initial begin
    RST = 1'b0; A = 1'b0; B = 1'b0; Load = 1'b0; IN = '0; Clear = 1'b0;
    ab_cur = 2'b00;
    model_reset();
    #1;
    chk_reset_values();
    repeat (3) tick();
    RST = 1'b1;

    // 1: settle after release
    hold(2'b00, 5);
    chk("t1_counter", 8'(Counter), 8'h00);

    // 2: load 7, four forward steps
    load(5'b00111);
    hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 4);
    chk("t2_counter", 8'(Counter), 8'h0b);

    // 3: four reverse steps
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
    chk("t3_counter", 8'(Counter), 8'h07);

    // 4: saturation at both ends
    load(5'b11110);
    hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4);
    chk("t4_high", 8'(High), 8'h01);
    chk("t4_max",  8'(Counter), 8'h1f);
    load(5'b00001);
    hold(2'b11, 4); hold(2'b01, 4);
    chk("t4_min", 8'(Counter), 8'h00);
    chk("t4_low", 8'(Low), 8'h01);

    // 5: illegal transitions, Clear, and set-beats-clear
    hold(2'b00, 4); hold(2'b11, 4);
    chk("t5_err_set", 8'(Err), 8'h01);
    Clear = 1'b1; tick(); Clear = 1'b0;
    chk("t5_err_clr", 8'(Err), 8'h00);
    hold(2'b01, 4);
    hold(2'b10, 2);
    Clear = 1'b1; tick(); Clear = 1'b0;
    chk("t5_err_win", 8'(Err), 8'h01);
    hold(2'b10, 3);

    // 6: load coinciding with an up step, then reset mid-sequence
    hold(2'b00, 2);
    load(5'b10000);
    chk("t6_load_cnt", 8'(Counter), 8'h10);
    chk("t6_load_up",  8'(Up), 8'h01);
    hold(2'b00, 3);
    hold(2'b01, 2);
    RST = 1'b0;
    model_reset();
    #1;
    chk_reset_values();
    hold(2'b11, 2);
    RST = 1'b1;
    hold(2'b11, 6);
    chk("t6_no_step", 8'(Counter), 8'h00);
    hold(2'b10, 4);
    chk("t6_step", 8'(Counter), 8'h01);

    // randomized walk with occasional illegal jumps, loads and clears
    for (int i = 0; i < 300; i++) begin
      int r;
      int n;
      logic [1:0] nx;
      r = $urandom_range(0, 9);
      if (r < 5)      nx = fwd_next(ab_cur);
      else if (r < 9) nx = rev_next(ab_cur);
      else            nx = ab_cur ^ 2'b11;
      n = $urandom_range(1, 5);
      ab_cur = nx;
      A = nx[1];
      B = nx[0];
      for (int j = 0; j < n; j++) begin
        Load  = ($urandom_range(0, 11) == 0);
        IN    = WIDTH'($urandom);
        Clear = ($urandom_range(0, 7) == 0);
        tick();
      end
      Load  = 1'b0;
      Clear = 1'b0;
    end
    hold(ab_cur, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Quadrature decoder that receives the two-phase A/B signals of a rotary/linear encoder and turns them into up/down steps on an internal saturating position counter. It is the receiving end of the step interface our up/down counter consumes. It decodes direction from the Gray-coded A/B sequence and drives Counter/High/Low with the same semantics as our counter. It also exports one-cycle Up/Down step pulses for downstream blocks.

Parameters:
WIDTH, 5, width of position counter and IN
SYNC_STAGES, 2, flip-flop synchronizer depth on each of A and B (min 2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
A  input  1  encoder phase A, asynchronous to CLK
B  input  1  encoder phase B, asynchronous to CLK
Load  input  1  synchronous load of IN into Counter
IN  input  WIDTH  load value
Clear  input  1  synchronous clear of Err
Counter  output  WIDTH  current position
High  output  1  Counter == all ones
Low  output  1  Counter == 0
Up  output  1  one-cycle pulse: forward step decoded
Down  output  1  one-cycle pulse: reverse step decoded
Err  output  1  sticky: illegal A/B transition seen

Behaviour:
- Reset (RST=0, takes effect immediately):
  - synchronizer flops = 0, prev phase = 00, Counter = 0, Up = Down = Err = 0.
  - High = 0, Low = 1. High/Low are decoded combinationally from the Counter register.
- Synchronizer: A and B each pass through SYNC_STAGES flops. Decode uses only the last stage (phase S = {A_s, B_s}).
- FSM PRIME -> TRACK:
  - PRIME is entered on reset and lasts SYNC_STAGES+1 cycles (prime counter).
  - On exit from PRIME, prev is loaded with S. No step is counted, whatever the A/B level at reset release.
  - Load is honoured in PRIME.
  - TRACK persists until the next reset.
- Decode in TRACK, comparing prev vs S each cycle; prev <= S every cycle.
  - Forward (Up) sequence: 00->01->11->10->00.
  - Reverse (Down) sequence: the opposite order.
  - S == prev: no action.
  - Both bits changed (00<->11, 01<->10): illegal. Set Err, no step, no pulse.
- Latency:
  - An A/B change sampled at edge k appears in S after edge k+SYNC_STAGES-1.
  - Counter, Up and Down are all registered and update at edge k+SYNC_STAGES (3 edges total for the default).
- Up/Down:
  - Each pulse is high for exactly one cycle per decoded step. Up and Down are never high together.
  - Pulses reflect the decoded step even when the counter is saturated or Load is active.
- Counter update priority:
  - Load: Counter <= IN. Any coincident step is dropped from Counter, but its pulse is still issued.
  - else Up step and Counter != max: Counter + 1.
  - else Down step and Counter != 0: Counter - 1.
  - else hold.
- Saturation, not wrap-around: at all ones an Up step holds the value; at 0 a Down step holds it.
- Err: set by an illegal transition and cleared by Clear. If set and Clear coincide, set wins (Err = 1). Err does not block counting of later legal steps.
- Reset mid-operation clears all state at once. Decoding restarts with PRIME.

Test Plan (WIDTH=5, SYNC_STAGES=2, each A/B value held >= 4 cycles):
1. Reset with A=B=0, release, wait 5 cycles -> Counter=00000, Low=1, High=0, Err=0, no Up/Down pulse.
2. Load IN=00111 (1 cycle), then drive AB 01,11,10,00 -> Counter=00111, then 01011. Four single-cycle Up pulses, each 3 edges after its AB change; Down stays 0.
3. From 01011 drive AB 10,11,01,00 -> Counter=00111, four Down pulses, Up stays 0.
4. Load 11110, then 3 forward steps -> Counter=11111 after the first step and holds, High=1, 3 Up pulses. Then Load 00001 and 2 reverse steps -> Counter=00000, Low=1, 2 Down pulses.
5. AB 00->11 -> Err=1, Counter unchanged, no pulse. Then Clear=1 -> Err=0 next edge. Then Clear=1 in the same cycle as an illegal 01->10 decode -> Err stays 1.
6. Load IN=10000 in the cycle an Up step is decoded -> Counter=10000 and Up pulses. Then assert RST mid-sequence -> outputs at reset values immediately. Release with AB=11 -> no step counted. Then AB 11->10 -> Counter=00001, one Up pulse.
